// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage.
// Opcodes, multiplier FSM encoding and XM bubble values.
package ex_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int MUL_CYC = 32;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_LW  = 4'd11;
  localparam logic [3:0] OP_SW  = 4'd12;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mul_state_t;

  localparam logic [DATA_W-1:0] BUB_ALU = '0;
  localparam logic [REG_AW-1:0] BUB_RD  = '0;
  localparam logic              BUB_RDF = 1'b0;

endpackage

// File: rtl/ex_stage_seq_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// done and p are valid together on the final iteration.
module seq_multiplier
  import ex_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_CYC = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] p
);

  localparam int CW = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

  mul_state_t        state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] sum;
  logic              last;

  assign sum  = acc + (mplier[0] ? mcand : '0);
  assign last = (state == S_BUSY) && (cnt == CW'(MUL_CYC - 1));
  assign busy = (state == S_BUSY);
  assign done = last;
  assign p    = sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_BUSY;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
          end
        end
        S_BUSY: begin
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding, ALU, load-use detect, XM register.
// MUL runs on the iterative multiplier and stalls ID while busy.
module ex_stage
  import ex_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int MUL_CYC = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dx_valid,
  input  logic [3:0]        dx_op,
  input  logic [REG_AW-1:0] dx_rs,
  input  logic [REG_AW-1:0] dx_rt,
  input  logic [REG_AW-1:0] dx_rd,
  input  logic [DATA_W-1:0] dx_a,
  input  logic [DATA_W-1:0] dx_b,
  input  logic [DATA_W-1:0] dx_imm,
  input  logic              dx_use_imm,
  input  logic [REG_AW-1:0] mw_rd,
  input  logic [DATA_W-1:0] mw_alu_out,
  output logic [DATA_W-1:0] xm_alu_out,
  output logic [REG_AW-1:0] xm_rd,
  output logic              xm_rdf,
  output logic              xm_rdf2,
  output logic              ex_stall
);

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] addr;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] res;
  logic [REG_AW-1:0] res_rd;
  logic              res_rdf;
  logic              res_rdf2;
  logic              xm_fa;
  logic              xm_fb;
  logic              mw_fa;
  logic              mw_fb;
  logic              rt_used;
  logic              load_use;
  logic              mul_start;
  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_p;
  logic [REG_AW-1:0] mul_rd;

  // A load in XM has no data yet, so it never forwards.
  assign xm_fa = !xm_rdf && xm_rd != '0 && xm_rd == dx_rs;
  assign xm_fb = !xm_rdf && xm_rd != '0 && xm_rd == dx_rt;
  assign mw_fa = mw_rd != '0 && mw_rd == dx_rs;
  assign mw_fb = mw_rd != '0 && mw_rd == dx_rt;

  assign fwd_a = xm_fa ? xm_alu_out : mw_fa ? mw_alu_out : dx_a;
  assign fwd_b = xm_fb ? xm_alu_out : mw_fb ? mw_alu_out : dx_b;

  assign op_b  = (dx_use_imm && dx_op != OP_SW) ? dx_imm : fwd_b;
  assign addr  = fwd_a + dx_imm;
  assign shamt = dx_imm[10:6];

  assign rt_used  = !dx_use_imm || dx_op == OP_SW;
  assign load_use = dx_valid && xm_rdf && xm_rdf2 && xm_rd != '0 &&
                    (xm_rd == dx_rs || (xm_rd == dx_rt && rt_used));

  assign mul_start = dx_valid && dx_op == OP_MUL &&
                     !load_use && !mul_busy;
  assign ex_stall  = load_use || mul_busy;

  seq_multiplier #(
    .DATA_W  (DATA_W),
    .MUL_CYC (MUL_CYC)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (fwd_a),
    .b     (fwd_b),
    .busy  (mul_busy),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_comb begin
    res      = '0;
    res_rd   = dx_rd;
    res_rdf  = 1'b0;
    res_rdf2 = 1'b0;
    unique case (dx_op)
      OP_ADD: res = fwd_a + op_b;
      OP_SUB: res = fwd_a - op_b;
      OP_AND: res = fwd_a & op_b;
      OP_OR:  res = fwd_a | op_b;
      OP_XOR: res = fwd_a ^ op_b;
      OP_NOR: res = ~(fwd_a | op_b);
      OP_SLT: res = {{(DATA_W-1){1'b0}},
                     $signed(fwd_a) < $signed(op_b)};
      OP_SLL: res = op_b << shamt;
      OP_SRL: res = op_b >> shamt;
      OP_SRA: res = $unsigned($signed(op_b) >>> shamt);
      OP_LW: begin
        res      = addr;
        res_rdf  = 1'b1;
        res_rdf2 = 1'b1;
      end
      OP_SW: begin
        res     = fwd_b;
        res_rd  = addr[REG_AW-1:0];
        res_rdf = 1'b1;
      end
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xm_alu_out <= BUB_ALU;
      xm_rd      <= BUB_RD;
      xm_rdf     <= BUB_RDF;
      xm_rdf2    <= 1'b0;
      mul_rd     <= '0;
    end else begin
      if (mul_start) mul_rd <= dx_rd;
      if (mul_done) begin
        xm_alu_out <= mul_p;
        xm_rd      <= mul_rd;
        xm_rdf     <= 1'b0;
        xm_rdf2    <= 1'b0;
      end else if (!dx_valid || ex_stall || dx_op == OP_MUL) begin
        xm_alu_out <= BUB_ALU;
        xm_rd      <= BUB_RD;
        xm_rdf     <= BUB_RDF;
        xm_rdf2    <= 1'b0;
      end else begin
        xm_alu_out <= res;
        xm_rd      <= res_rd;
        xm_rdf     <= res_rdf;
        xm_rdf2    <= res_rdf2;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, forwarding, load-use,
// SW, multi-cycle MUL and reset during MUL.
module tb_ex_stage;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        dx_valid;
  logic [3:0]  dx_op;
  logic [4:0]  dx_rs;
  logic [4:0]  dx_rt;
  logic [4:0]  dx_rd;
  logic [31:0] dx_a;
  logic [31:0] dx_b;
  logic [31:0] dx_imm;
  logic        dx_use_imm;
  logic [4:0]  mw_rd;
  logic [31:0] mw_alu_out;
  logic [31:0] xm_alu_out;
  logic [4:0]  xm_rd;
  logic        xm_rdf;
  logic        xm_rdf2;
  logic        ex_stall;

  int total = 0;
  int bad   = 0;
  int stall_cnt;
  int bub_cnt;
  logic [31:0] seen;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk        (clk),
    .rst        (rst),
    .dx_valid   (dx_valid),
    .dx_op      (dx_op),
    .dx_rs      (dx_rs),
    .dx_rt      (dx_rt),
    .dx_rd      (dx_rd),
    .dx_a       (dx_a),
    .dx_b       (dx_b),
    .dx_imm     (dx_imm),
    .dx_use_imm (dx_use_imm),
    .mw_rd      (mw_rd),
    .mw_alu_out (mw_alu_out),
    .xm_alu_out (xm_alu_out),
    .xm_rd      (xm_rd),
    .xm_rdf     (xm_rdf),
    .xm_rdf2    (xm_rdf2),
    .ex_stall   (ex_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic ui);
    dx_valid   = 1'b1;
    dx_op      = op;
    dx_rs      = rs;
    dx_rt      = rt;
    dx_rd      = rd;
    dx_a       = a;
    dx_b       = b;
    dx_imm     = imm;
    dx_use_imm = ui;
  endtask

  initial begin
    rst = 1'b1;
    dx_valid = 1'b0;
    dx_op = OP_ADD;
    dx_rs = 0; dx_rt = 0; dx_rd = 0;
    dx_a = 0; dx_b = 0; dx_imm = 0;
    dx_use_imm = 1'b0;
    mw_rd = 0; mw_alu_out = 0;
    tick(); tick();
    chk("rst_alu", xm_alu_out, 32'd0);
    chk("rst_rd", 32'(xm_rd), 32'd0);
    chk("rst_rdf", 32'(xm_rdf), 32'd0);
    chk("rst_rdf2", 32'(xm_rdf2), 32'd0);
    chk("rst_stall", 32'(ex_stall), 32'd0);
    rst = 1'b0;

    issue(OP_ADD, 1, 2, 3, 5, 7, 0, 0);
    tick();
    chk("add_alu", xm_alu_out, 32'd12);
    chk("add_rd", 32'(xm_rd), 32'd3);
    chk("add_rdf", 32'(xm_rdf), 32'd0);

    issue(OP_ADD, 1, 2, 3, 1, 2, 0, 0);
    tick();
    chk("add3_alu", xm_alu_out, 32'd3);
    issue(OP_SUB, 3, 0, 4, 0, 0, 1, 1);
    tick();
    chk("xm_fwd_alu", xm_alu_out, 32'd2);
    chk("xm_fwd_rd", 32'(xm_rd), 32'd4);

    mw_rd = 5; mw_alu_out = 32'h100;
    issue(OP_OR, 5, 6, 7, 0, 32'h0F, 0, 0);
    tick();
    chk("mw_fwd_or", xm_alu_out, 32'h10F);

    mw_rd = 7; mw_alu_out = 32'h999;
    issue(OP_ADD, 7, 0, 8, 0, 0, 0, 0);
    tick();
    chk("xm_prio", xm_alu_out, 32'h10F);
    mw_rd = 0; mw_alu_out = 32'h55;

    issue(OP_ADD, 0, 0, 0, 5, 0, 0, 0);
    tick();
    chk("r0_dst_rd", 32'(xm_rd), 32'd0);
    issue(OP_ADD, 0, 0, 9, 1, 1, 0, 0);
    tick();
    chk("r0_nofwd", xm_alu_out, 32'd2);

    issue(OP_SLL, 0, 0, 9, 0, 32'h1, 32'h100, 0);
    tick();
    chk("sll", xm_alu_out, 32'h10);
    issue(OP_SRL, 0, 0, 9, 0, 32'h8000_0000, 32'h100, 0);
    tick();
    chk("srl", xm_alu_out, 32'h0800_0000);
    issue(OP_SRA, 0, 0, 9, 0, 32'h8000_0000, 32'h100, 0);
    tick();
    chk("sra", xm_alu_out, 32'hF800_0000);
    issue(OP_SLT, 0, 0, 9, 32'hFFFF_FFFF, 32'h1, 0, 0);
    tick();
    chk("slt_neg", xm_alu_out, 32'd1);
    issue(OP_SLT, 0, 0, 9, 32'h1, 32'hFFFF_FFFF, 0, 0);
    tick();
    chk("slt_pos", xm_alu_out, 32'd0);
    issue(OP_NOR, 0, 0, 9, 32'h0F0F_0000, 32'h0000_00F0, 0, 0);
    tick();
    chk("nor", xm_alu_out, 32'hF0F0_FF0F);
    issue(OP_XOR, 0, 0, 9, 32'hFF00, 32'h0FF0, 0, 0);
    tick();
    chk("xor", xm_alu_out, 32'hF0F0);
    issue(OP_AND, 0, 0, 9, 32'hFF00, 32'h0FF0, 0, 0);
    tick();
    chk("and", xm_alu_out, 32'h0F00);
    issue(OP_SUB, 0, 0, 9, 0, 1, 0, 0);
    tick();
    chk("sub_wrap", xm_alu_out, 32'hFFFF_FFFF);

    issue(OP_LW, 0, 0, 5, 4, 0, 5, 1);
    tick();
    chk("lw_alu", xm_alu_out, 32'd9);
    chk("lw_rd", 32'(xm_rd), 32'd5);
    chk("lw_rdf", 32'(xm_rdf), 32'd1);
    chk("lw_rdf2", 32'(xm_rdf2), 32'd1);
    issue(OP_ADD, 5, 0, 6, 0, 0, 1, 1);
    #1;
    chk("lu_stall", 32'(ex_stall), 32'd1);
    tick();
    chk("lu_bub_alu", xm_alu_out, 32'd0);
    chk("lu_bub_rdf", 32'(xm_rdf), 32'd0);
    mw_rd = 5; mw_alu_out = 32'h40;
    #1;
    chk("lu_stall_off", 32'(ex_stall), 32'd0);
    tick();
    chk("lu_mw_fwd", xm_alu_out, 32'h41);
    chk("lu_mw_rd", 32'(xm_rd), 32'd6);
    mw_rd = 0; mw_alu_out = 0;

    issue(OP_SW, 0, 0, 9, 4, 32'hDEAD, 3, 1);
    tick();
    chk("sw_rdf", 32'(xm_rdf), 32'd1);
    chk("sw_rdf2", 32'(xm_rdf2), 32'd0);
    chk("sw_rd", 32'(xm_rd), 32'd7);
    chk("sw_alu", xm_alu_out, 32'hDEAD);

    issue(OP_MUL, 0, 0, 8, 32'hFFFF_FFFF, 32'd3, 0, 0);
    #1;
    chk("mul_acc_stall", 32'(ex_stall), 32'd0);
    stall_cnt = 0;
    bub_cnt = 0;
    tick();
    issue(OP_ADD, 0, 0, 9, 10, 20, 0, 0);
    for (int i = 0; i < MUL_CYC; i++) begin
      if (ex_stall === 1'b1) stall_cnt++;
      if (xm_alu_out === 32'd0 && xm_rd === 5'd0 && xm_rdf === 1'b0)
        bub_cnt++;
      tick();
    end
    chk("mul_stall_cyc", 32'(stall_cnt), 32'd32);
    chk("mul_bubbles", 32'(bub_cnt), 32'd32);
    chk("mul_p", xm_alu_out, 32'hFFFF_FFFD);
    chk("mul_rd", 32'(xm_rd), 32'd8);
    chk("mul_done_stall", 32'(ex_stall), 32'd0);
    tick();
    chk("held_issue", xm_alu_out, 32'd30);
    chk("held_rd", 32'(xm_rd), 32'd9);

    issue(OP_MUL, 0, 0, 10, 32'd7, 32'd9, 0, 0);
    tick();
    dx_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_alu", xm_alu_out, 32'd0);
    chk("mrst_rd", 32'(xm_rd), 32'd0);
    chk("mrst_rdf", 32'(xm_rdf), 32'd0);
    chk("mrst_stall", 32'(ex_stall), 32'd0);
    seen = 0;
    for (int i = 0; i < 34; i++) begin
      if (xm_rd === 5'd10 || xm_alu_out === 32'd63) seen = seen + 1;
      tick();
    end
    chk("mrst_no_prod", seen, 32'd0);
    issue(OP_ADD, 0, 0, 2, 2, 3, 0, 0);
    tick();
    chk("post_rst_add", xm_alu_out, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
